// File: rtl/mtx_arb_if.sv
// mtx_arb_if -- handshake bundle between the requesting channels, the
// matrix arbiter and the shared downstream port.
//
//   in_valid  [NUM_CH]             per-channel beat valid
//   in_last   [NUM_CH]             per-channel last beat of packet
//   in_data   [NUM_CH*DATA_WIDTH]  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready  [NUM_CH]             per-channel accept (at most one bit high)
//   out_valid / out_last / out_data / out_ch   shared port, granted channel
//   out_ready                      downstream accept
//
// slave modport  : arbiter view.
// master modport : view of the environment driving channels and downstream.
interface mtx_arb_if #(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_last;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_ready;
    logic                         out_valid;
    logic                         out_last;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_ready;

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_ch
    );

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_ch
    );
endinterface

// File: rtl/mtx_arb.sv
// mtx_arb -- packet-locked matrix arbiter.
//
// Arbitrates NUM_CH requesting channels onto one shared port. In IDLE the
// winner is chosen round-robin from rr_ptr (or lowest index when
// test_mode_en is high); the grant is then held in LOCKED, passing beats
// through combinationally, until a transfer with out_last. One IDLE bubble
// separates packets.
//
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst       asynchronous active-high reset
//   test_mode_en  fixed priority (lowest index wins) when high
//   bus           mtx_arb_if.slave handshake bundle
//   busy          high while LOCKED
//   wdog_err      sticky watchdog timeout flag
//
// Build option: define MTX_ARB_WATCHDOG_EN to enable the stall watchdog
// (WDOG_CYCLES consecutive LOCKED cycles without a transfer abort the
// grant and set wdog_err). Without it wdog_err is tied low.
module mtx_arb #(
    parameter int NUM_CH      = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WDOG_CYCLES = 255
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         test_mode_en,
    mtx_arb_if.slave     bus,
    output logic         busy,
    output logic         wdog_err
);
    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    if (NUM_CH < 2 || NUM_CH > 32) begin : g_bad_num_ch
        $error("mtx_arb: NUM_CH out of range");
    end
    if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_wdog
        $error("mtx_arb: WDOG_CYCLES out of range");
    end

    logic [0:0]            state_q;
    logic [CH_W-1:0]       gnt_q;
    logic [CH_W-1:0]       rr_ptr_q;
    logic [CH_W-1:0]       winner;
    logic [CH_W-1:0]       next_ptr;
    logic [NUM_CH-1:0]     gnt_mask;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  locked;
    logic                  any_req;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  xfer;
    logic                  wdog_fire;

    assign locked    = (state_q == LOCKED);
    assign any_req   = |bus.in_valid;
    assign sel_valid = bus.in_valid[gnt_q];
    assign sel_last  = bus.in_last[gnt_q];
    assign xfer      = locked && sel_valid && bus.out_ready;
    assign next_ptr  = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

    // Winner selection: scan from rr_ptr upward with explicit wrap so that
    // non-power-of-two NUM_CH never indexes past the last channel.
    always_comb begin
        logic        found;
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (test_mode_en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (!found && bus.in_valid[i]) begin
                    winner = CH_W'(i);
                    found  = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                idx = 32'(rr_ptr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (!found && bus.in_valid[idx[CH_W-1:0]]) begin
                    winner = idx[CH_W-1:0];
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_mask = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (gnt_q == CH_W'(i)) begin
                gnt_mask[i] = locked;
                sel_data    = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef MTX_ARB_WATCHDOG_EN
    logic [15:0] wdog_cnt_q;
    logic        wdog_err_q;

    // Fires on the stall cycle that would bring the count to WDOG_CYCLES.
    assign wdog_fire = locked && !xfer && (wdog_cnt_q == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (!locked || xfer || wdog_fire) begin
                wdog_cnt_q <= '0;
            end else begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end
            if (wdog_fire) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= LOCKED;
                        gnt_q   <= winner;
                    end
                end
                default: begin
                    if ((xfer && sel_last) || wdog_fire) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= next_ptr;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = locked && sel_valid;
    assign bus.out_last  = locked && sel_last;
    assign bus.out_data  = locked ? sel_data : '0;
    assign bus.out_ch    = gnt_q;
    assign bus.in_ready  = gnt_mask & {NUM_CH{bus.out_ready}};
    assign busy          = locked;
endmodule

// File: tb/tb_mtx_arb.sv
// tb_mtx_arb -- self-checking bench for mtx_arb (NUM_CH=32, DATA_WIDTH=32,
// WDOG_CYCLES=255). Directed scenarios plus a randomized run, all compared
// against a transaction-level reference model of the arbitration rules.
// Watchdog expectations follow MTX_ARB_WATCHDOG_EN as seen by this file.
module tb_mtx_arb;
    localparam int N  = 32;
    localparam int DW = 32;
    localparam int WD = 255;

    logic sys_clk;
    logic sys_rst;
    logic test_mode_en;
    logic busy;
    logic wdog_err;

    int n_vec = 0;
    int n_err = 0;

    mtx_arb_if #(.NUM_CH(N), .DATA_WIDTH(DW)) bus ();

    mtx_arb #(.NUM_CH(N), .DATA_WIDTH(DW), .WDOG_CYCLES(WD)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .test_mode_en (test_mode_en),
        .bus          (bus),
        .busy         (busy),
        .wdog_err     (wdog_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model: packet-level view of who owns the port.
    bit          m_locked;
    int          m_gnt;
    int          m_rr;
    int          m_stall;
    bit          m_err;
    logic          e_valid;
    logic          e_last;
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_ready;
    int            e_ch;
    logic          e_busy;

    function automatic void model_reset();
        m_locked = 0;
        m_gnt    = 0;
        m_rr     = 0;
        m_stall  = 0;
        m_err    = 0;
    endfunction

    function automatic void model_eval();
        if (sys_rst) model_reset();
        e_busy  = m_locked;
        e_ch    = m_gnt;
        e_valid = m_locked && bus.in_valid[m_gnt];
        e_last  = m_locked && bus.in_last[m_gnt];
        e_data  = m_locked ? bus.in_data[m_gnt*DW +: DW] : '0;
        e_ready = '0;
        if (m_locked && bus.out_ready) e_ready[m_gnt] = 1'b1;
    endfunction

    function automatic void model_clock();
        if (sys_rst) begin
            model_reset();
            return;
        end
        if (!m_locked) begin
            if (bus.in_valid != '0) begin
                int w = -1;
                if (test_mode_en) begin
                    for (int c = 0; c < N; c++)
                        if (w < 0 && bus.in_valid[c]) w = c;
                end else begin
                    for (int k = 0; k < N; k++)
                        if (w < 0 && bus.in_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
                end
                m_locked = 1;
                m_gnt    = w;
                m_stall  = 0;
            end
        end else if (bus.in_valid[m_gnt] && bus.out_ready) begin
            m_stall = 0;
            if (bus.in_last[m_gnt]) begin
                m_locked = 0;
                m_rr     = (m_gnt + 1) % N;
            end
        end else begin
            m_stall++;
`ifdef MTX_ARB_WATCHDOG_EN
            if (m_stall >= WD) begin
                m_locked = 0;
                m_rr     = (m_gnt + 1) % N;
                m_err    = 1;
                m_stall  = 0;
            end
`endif
        end
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        model_clock();
        @(negedge sys_clk);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) bus.in_data[i*DW +: DW] = $urandom();
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        #1;
        model_eval();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        bus.in_valid  = '1;
        bus.in_last   = '1;
        bus.out_ready = 1'b1;
        rand_data();
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== '0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got v=%b rdy=%h busy=%b exp 0/0/0", c, bus.out_valid, bus.in_ready, busy);
            end
            n_vec++;
            if (bus.out_ch !== 5'd0 || bus.out_data !== '0 || bus.out_last !== 1'b0 || wdog_err !== 1'b0) begin
                n_err++;
                $display("FAIL reset_vals got ch=%0d data=%h last=%b err=%b exp 0", bus.out_ch, bus.out_data, bus.out_last, wdog_err);
            end
            tick();
        end
        sys_rst = 1'b0;
        bus.in_valid = '0;
        bus.in_last  = '0;
    endtask

    task automatic test_alternate();
        int seq[$];
        int exp_seq[4] = '{0, 2, 0, 2};
        do_reset();
        bus.in_valid  = 32'h0000_0005;
        bus.in_last   = '1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            settle();
            n_vec++;
            if (bus.out_valid !== e_valid || bus.in_ready !== e_ready || bus.out_data !== e_data) begin
                n_err++;
                $display("FAIL alt_beat cyc=%0d got v=%b rdy=%h d=%h exp v=%b rdy=%h d=%h",
                         c, bus.out_valid, bus.in_ready, bus.out_data, e_valid, e_ready, e_data);
            end
            if (bus.out_valid && bus.out_ready) seq.push_back(int'(bus.out_ch));
            tick();
        end
        n_vec++;
        if (seq.size() != 4) begin
            n_err++;
            $display("FAIL alt_count got %0d packets exp 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (seq[i] != exp_seq[i]) begin
                    n_err++;
                    $display("FAIL alt_seq[%0d] got ch%0d exp ch%0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_rr_wrap();
        int seq[$];
        do_reset();
        bus.in_valid  = '1;
        bus.in_last   = '1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 66; c++) begin
            rand_data();
            settle();
            if (bus.out_valid && bus.out_ready) seq.push_back(int'(bus.out_ch));
            tick();
        end
        n_vec++;
        if (seq.size() != 33) begin
            n_err++;
            $display("FAIL rr_count got %0d packets exp 33", seq.size());
        end else begin
            for (int i = 0; i < 33; i++) begin
                n_vec++;
                if (seq[i] != i % N) begin
                    n_err++;
                    $display("FAIL rr_seq[%0d] got ch%0d exp ch%0d", i, seq[i], i % N);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.in_valid  = 32'h0000_0040;
        bus.in_last   = '1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            settle();
            n_vec++;
            if (busy !== 1'((c % 2) == 1) || (busy && bus.out_ch !== 5'd6)) begin
                n_err++;
                $display("FAIL b2b cyc=%0d got busy=%b ch=%0d exp busy=%b ch=6", c, busy, bus.out_ch, (c % 2) == 1);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        int beats3  = 0;
        int c_last3 = -1;
        int c_gnt7  = -1;
        logic [DW-1:0] d3;
        do_reset();
        bus.in_last = '0;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid    = 32'h0000_0080;
            bus.in_valid[3] = (beats3 < 4);
            bus.in_last[3]  = (beats3 == 3);
            bus.in_last[7]  = 1'b1;
            bus.out_ready   = 1'((c % 2) == 1);
            rand_data();
            d3 = $urandom();
            bus.in_data[3*DW +: DW] = d3;
            settle();
            n_vec++;
            if (bus.in_ready !== e_ready || bus.out_valid !== e_valid || busy !== e_busy) begin
                n_err++;
                $display("FAIL hold_hs cyc=%0d got rdy=%h v=%b busy=%b exp rdy=%h v=%b busy=%b",
                         c, bus.in_ready, bus.out_valid, busy, e_ready, e_valid, e_busy);
            end
            if (busy && bus.out_ch == 5'd7 && c_gnt7 < 0) c_gnt7 = c;
            if (bus.out_valid && bus.out_ready && bus.out_ch == 5'd3) begin
                n_vec++;
                if (bus.out_data !== d3) begin
                    n_err++;
                    $display("FAIL hold_data beat=%0d got %h exp %h", beats3, bus.out_data, d3);
                end
                if (bus.out_last) c_last3 = c;
                beats3++;
            end
            tick();
        end
        n_vec++;
        if (beats3 != 4 || c_gnt7 != c_last3 + 2) begin
            n_err++;
            $display("FAIL hold_seq got beats=%0d gnt7@%0d exp beats=4 gnt7@%0d", beats3, c_gnt7, c_last3 + 2);
        end
        bus.in_valid = '0;
    endtask

    task automatic test_test_mode();
        int n4 = 0;
        int bad = 0;
        do_reset();
        bus.in_valid  = 32'h0000_0010;
        bus.in_last   = '1;
        bus.out_ready = 1'b1;
        settle();
        tick();
        settle();
        tick();
        test_mode_en = 1'b1;
        bus.in_valid = 32'h0000_0090;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            settle();
            if (bus.out_valid && bus.out_ready) begin
                if (bus.out_ch == 5'd4) n4++;
                else bad++;
            end
            tick();
        end
        n_vec++;
        if (n4 != 4 || bad != 0) begin
            n_err++;
            $display("FAIL tmode_grants got ch4=%0d other=%0d exp ch4=4 other=0", n4, bad);
        end
        test_mode_en = 1'b0;
        settle();
        tick();
        settle();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 5'd7) begin
            n_err++;
            $display("FAIL tmode_rr got v=%b ch=%0d exp v=1 ch=7", bus.out_valid, bus.out_ch);
        end
        tick();
        bus.in_valid = '0;
    endtask

    task automatic test_watchdog();
        int  run     = 0;
        bit  dropped = 0;
        int  next_ch = -1;
        do_reset();
        bus.in_valid  = 32'h0000_0006;
        bus.in_last   = '1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 300; c++) begin
            rand_data();
            settle();
            n_vec++;
            if (busy !== e_busy || wdog_err !== m_err || int'(bus.out_ch) != e_ch) begin
                n_err++;
                $display("FAIL wdog_state cyc=%0d got busy=%b err=%b ch=%0d exp busy=%b err=%b ch=%0d",
                         c, busy, wdog_err, bus.out_ch, e_busy, m_err, e_ch);
            end
            if (busy && !dropped) run++;
            else if (!busy && run > 0) dropped = 1;
            if (busy && dropped && next_ch < 0) next_ch = int'(bus.out_ch);
            tick();
        end
`ifdef MTX_ARB_WATCHDOG_EN
        n_vec++;
        if (run != WD || next_ch != 2 || wdog_err !== 1'b1) begin
            n_err++;
            $display("FAIL wdog_fire got run=%0d next=%0d err=%b exp run=%0d next=2 err=1", run, next_ch, wdog_err, WD);
        end
`else
        n_vec++;
        if (run != 299 || dropped || wdog_err !== 1'b0) begin
            n_err++;
            $display("FAIL wdog_off got run=%0d dropped=%b err=%b exp run=299 dropped=0 err=0", run, dropped, wdog_err);
        end
`endif
        bus.in_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.in_valid  = 32'h0000_0200;
        bus.in_last   = '1;
        bus.out_ready = 1'b1;
        settle();
        tick();
        settle();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 5'd9) begin
            n_err++;
            $display("FAIL rmid_pkt1 got v=%b ch=%0d exp v=1 ch=9", bus.out_valid, bus.out_ch);
        end
        tick();
        bus.in_last = '0;
        settle();
        tick();
        settle();
        tick();
        settle();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 5'd9 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_beat2 got v=%b ch=%0d busy=%b exp v=1 ch=9 busy=1", bus.out_valid, bus.out_ch, busy);
        end
        sys_rst = 1'b1;
        settle();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== '0 || busy !== 1'b0 || bus.out_ch !== 5'd0 || bus.out_data !== '0) begin
            n_err++;
            $display("FAIL rmid_async got v=%b rdy=%h busy=%b ch=%0d d=%h exp all 0",
                     bus.out_valid, bus.in_ready, busy, bus.out_ch, bus.out_data);
        end
        tick();
        sys_rst = 1'b0;
        bus.in_valid = 32'h0000_1200;
        bus.in_last  = '1;
        settle();
        tick();
        settle();
        n_vec++;
        if (busy !== 1'b1 || bus.out_ch !== 5'd9) begin
            n_err++;
            $display("FAIL rmid_regrant got busy=%b ch=%0d exp busy=1 ch=9", busy, bus.out_ch);
        end
        tick();
        bus.in_valid = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            test_mode_en  = ($urandom_range(7) == 0);
            bus.in_valid  = $urandom() & $urandom() & $urandom();
            bus.in_last   = $urandom() & $urandom();
            bus.out_ready = ($urandom_range(3) != 0);
            rand_data();
            settle();
            n_vec++;
            if (bus.out_valid !== e_valid || bus.out_last !== e_last || bus.out_data !== e_data) begin
                n_err++;
                $display("FAIL rnd_out cyc=%0d got v=%b l=%b d=%h exp v=%b l=%b d=%h",
                         c, bus.out_valid, bus.out_last, bus.out_data, e_valid, e_last, e_data);
            end
            n_vec++;
            if (bus.in_ready !== e_ready || int'(bus.out_ch) != e_ch || busy !== e_busy || wdog_err !== m_err) begin
                n_err++;
                $display("FAIL rnd_ctl cyc=%0d got rdy=%h ch=%0d busy=%b err=%b exp rdy=%h ch=%0d busy=%b err=%b",
                         c, bus.in_ready, bus.out_ch, busy, wdog_err, e_ready, e_ch, e_busy, m_err);
            end
            tick();
        end
        test_mode_en = 1'b0;
    endtask

    initial begin
        sys_rst       = 1'b1;
        test_mode_en  = 1'b0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge sys_clk);
        test_reset();
        test_alternate();
        test_rr_wrap();
        test_back_to_back();
        test_hold();
        test_test_mode();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
